// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: client and multiplier bus of the shared-multiplier arbiter
interface mul_share_arbiter_if #(
   parameter int N    = 4,
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] a_flat;
   logic [NREQ*N-1:0] b_flat;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [2*N-1:0]    result;
   logic              busy;
   logic              timeout_err;
   logic              mul_start;
   logic [N-1:0]      mul_multiplier;
   logic [N-1:0]      mul_multiplicand;
   logic              mul_ready;
   logic [2*N-1:0]    mul_product;
   modport slave (
      input  req, a_flat, b_flat, mul_ready, mul_product,
      output gnt, done, result, busy, timeout_err, mul_start, mul_multiplier, mul_multiplicand
   );
   modport master (
      output req, a_flat, b_flat, mul_ready, mul_product,
      input  gnt, done, result, busy, timeout_err, mul_start, mul_multiplier, mul_multiplicand
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one start/ready multiplier with a hang watchdog
module mul_share_arbiter #(
   parameter int N       = 4,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 32
) (
   input logic                clk,
   input logic                rst_n,
   mul_share_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;
   state_t          state, state_nx;
   logic [PW-1:0]   ptr, ptr_nx, owner, owner_nx;
   logic [WW-1:0]   wd, wd_nx;
   logic [NREQ-1:0] gnt_q, gnt_nx, done_q, done_nx;
   logic [2*N-1:0]  result_q, result_nx;
   logic            busy_q, busy_nx, err_q, err_nx, start_q, start_nx;
   logic [N-1:0]    ma_q, ma_nx, mb_q, mb_nx;
   logic            found;
   int              win;
   assign bus.gnt              = gnt_q;
   assign bus.done             = done_q;
   assign bus.result           = result_q;
   assign bus.busy             = busy_q;
   assign bus.timeout_err      = err_q;
   assign bus.mul_start        = start_q;
   assign bus.mul_multiplier   = ma_q;
   assign bus.mul_multiplicand = mb_q;
   // Register every state element and output; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         wd       <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         ma_q     <= '0;
         mb_q     <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         owner    <= owner_nx;
         wd       <= wd_nx;
         gnt_q    <= gnt_nx;
         done_q   <= done_nx;
         result_q <= result_nx;
         busy_q   <= busy_nx;
         err_q    <= err_nx;
         start_q  <= start_nx;
         ma_q     <= ma_nx;
         mb_q     <= mb_nx;
      end
   end
   // Round-robin pick starting at ptr, then sequence ISSUE -> WAIT -> IDLE or HALT on a hang
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      owner_nx  = owner;
      wd_nx     = wd;
      gnt_nx    = '0;
      done_nx   = '0;
      start_nx  = 1'b0;
      result_nx = result_q;
      err_nx    = err_q;
      ma_nx     = ma_q;
      mb_nx     = mb_q;
      found     = 1'b0;
      win       = 0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      case (state)
         IDLE: if (found) begin
            state_nx    = ISSUE;
            gnt_nx[win] = 1'b1;
            start_nx    = 1'b1;
            owner_nx    = PW'(win);
            ptr_nx      = (win == NREQ - 1) ? '0 : PW'(win + 1);
            ma_nx       = bus.a_flat[win*N +: N];
            mb_nx       = bus.b_flat[win*N +: N];
         end
         ISSUE: begin
            state_nx = WAIT;
            wd_nx    = '0;
         end
         WAIT: if (bus.mul_ready) begin
            state_nx       = IDLE;
            result_nx      = bus.mul_product;
            done_nx[owner] = 1'b1;
         end else if (wd == WW'(TIMEOUT - 1)) begin
            state_nx = HALT;
            err_nx   = 1'b1;
         end else begin
            wd_nx = wd + 1'b1;
         end
         default: ;
      endcase
      busy_nx = (state_nx != IDLE);
   end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench with a shift-add multiplier model
module tb_mul_share_arbiter;
   localparam int N = 4, NREQ = 2, TIMEOUT = 32, PW2 = 2 * N;
   typedef struct packed { logic [NREQ-1:0] oh; logic [PW2-1:0] p; } exp_t;
   logic              clk = 1'b0, rst_n = 1'b0, hang = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*N-1:0] a_flat = '0, b_flat = '0;
   logic              m_ready;
   logic [PW2-1:0]    acc, mcand;
   logic [N-1:0]      mplier;
   int                cnt;
   int                vectors = 0, miscompares = 0;
   exp_t              exp_q[$];
   mul_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
   mul_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   assign bus.req         = req;
   assign bus.a_flat      = a_flat;
   assign bus.b_flat      = b_flat;
   assign bus.mul_ready   = m_ready;
   assign bus.mul_product = acc;
   always #5 clk = ~clk;
   // Shift-add multiplier: N steps after start, ready stays high until the next start
   always @(posedge clk) begin
      if (!rst_n) begin
         m_ready <= 1'b0;
         cnt     <= 0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
      end else if (bus.mul_start) begin
         acc     <= '0;
         mcand   <= PW2'(bus.mul_multiplicand);
         mplier  <= bus.mul_multiplier;
         cnt     <= N;
         m_ready <= 1'b0;
      end else if (cnt != 0) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt - 1;
         m_ready <= (cnt == 1) && !hang;
      end
   end
   function automatic logic [PW2-1:0] prod(input int i);
      return PW2'(a_flat[i*N +: N]) * PW2'(b_flat[i*N +: N]);
   endfunction
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.gnt, bus.done, bus.result} !== '0) begin
         miscompares++;
         $display("FAIL reset_bus: got gnt=%b done=%b result=%0d want all 0", bus.gnt, bus.done, bus.result);
      end
      vectors++;
      if ({bus.busy, bus.timeout_err, bus.mul_start, bus.mul_multiplier, bus.mul_multiplicand} !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got busy=%b err=%b start=%b ops=%h/%h want 0", bus.busy, bus.timeout_err, bus.mul_start, bus.mul_multiplier, bus.mul_multiplicand);
      end
      rst_n = 1'b1;
   endtask
   task automatic test_single();
      exp_t e;
      a_flat = {4'd0, 4'd3};
      b_flat = {4'd0, 4'd5};
      req = 2'b01;
      exp_q.push_back({2'b01, prod(0)});
      @(negedge clk);
      vectors++;
      if (bus.gnt !== 2'b01 || bus.mul_start !== 1'b1 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_grant: got gnt=%b start=%b busy=%b want 01/1/1", bus.gnt, bus.mul_start, bus.busy);
      end
      vectors++;
      if ({bus.mul_multiplier, bus.mul_multiplicand} !== 8'h35) begin
         miscompares++;
         $display("FAIL single_operands: got %h want 35", {bus.mul_multiplier, bus.mul_multiplicand});
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if (bus.gnt !== 2'b00 || bus.mul_start !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pulse: got gnt=%b start=%b want 00/0", bus.gnt, bus.mul_start);
      end
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         if (bus.done !== '0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({bus.done, bus.result} !== e) begin
               miscompares++;
               $display("FAIL single_done: got %b/%0d want %b/%0d", bus.done, bus.result, e.oh, e.p);
            end
            vectors++;
            if (bus.busy !== 1'b0) begin
               miscompares++;
               $display("FAIL single_busy: got %b want 0", bus.busy);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL single_drain: %0d results missing want 0", exp_q.size());
         exp_q.delete();
      end
   endtask
   task automatic test_wide();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         a_flat = (k == 0) ? {4'd0, 4'd0} : {4'd15, 4'd0};
         b_flat = (k == 0) ? {4'd9, 4'd0} : {4'd15, 4'd0};
         req = 2'b10;
         exp_q.push_back({2'b10, prod(1)});
         for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = req & ~bus.gnt;
            if (bus.done !== '0) begin
               e = exp_q.pop_front();
               vectors++;
               if ({bus.done, bus.result} !== e) begin
                  miscompares++;
                  $display("FAIL wide_done: got %b/%0d want %b/%0d", bus.done, bus.result, e.oh, e.p);
               end
            end
         end
         vectors++;
         if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wide_drain: %0d results missing want 0", exp_q.size());
            exp_q.delete();
         end
      end
   endtask
   task automatic test_pair();
      exp_t e;
      for (int r = 0; r < 2; r++) begin
         a_flat = {4'd4, 4'd2};
         b_flat = {4'd4, 4'd7};
         req = 2'b11;
         exp_q.push_back({2'b01, prod(0)});
         exp_q.push_back({2'b10, prod(1)});
         for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            req = req & ~bus.gnt;
            if (bus.done !== '0) begin
               e = exp_q.pop_front();
               vectors++;
               if ({bus.done, bus.result} !== e) begin
                  miscompares++;
                  $display("FAIL pair_done: round %0d got %b/%0d want %b/%0d", r, bus.done, bus.result, e.oh, e.p);
               end
            end
         end
         vectors++;
         if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pair_drain: %0d results missing want 0", exp_q.size());
            exp_q.delete();
         end
      end
   endtask
   task automatic test_fairness();
      exp_t e;
      int n0 = 0;
      logic [NREQ-1:0] seen = '0;
      a_flat = {4'd2, 4'd1};
      b_flat = {4'd5, 4'd3};
      req = 2'b01;
      exp_q.push_back({2'b01, prod(0)});
      exp_q.push_back({2'b10, prod(1)});
      exp_q.push_back({2'b01, prod(0)});
      for (int c = 0; c < 120 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         if (bus.gnt[0]) n0++;
         if (bus.gnt[0] && n0 == 1) req[1] = 1'b1;
         if (bus.gnt[0] && n0 == 2) req[0] = 1'b0;
         if (bus.gnt[1]) req[1] = 1'b0;
         if (bus.done !== '0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({bus.done, bus.result} !== e) begin
               miscompares++;
               $display("FAIL fair_done: got %b/%0d want %b/%0d", bus.done, bus.result, e.oh, e.p);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL fair_drain: %0d results missing want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (8) begin
         @(negedge clk);
         seen = seen | bus.gnt | bus.done;
      end
      vectors++;
      if (seen !== '0) begin
         miscompares++;
         $display("FAIL fair_extra: got stray gnt/done %b want 00", seen);
      end
   endtask
   task automatic test_timeout();
      int n = 0;
      logic [NREQ-1:0] seen = '0;
      hang = 1'b1;
      a_flat = {4'd0, 4'd1};
      b_flat = {4'd0, 4'd1};
      req = 2'b01;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.gnt !== '0) break;
      end
      vectors++;
      if (bus.gnt !== 2'b01) begin
         miscompares++;
         $display("FAIL hang_grant: got %b want 01", bus.gnt);
      end
      req = '0;
      for (int c = 0; c < TIMEOUT + 10; c++) begin
         @(negedge clk);
         if (bus.timeout_err === 1'b1) break;
         n++;
      end
      vectors++;
      if (n != TIMEOUT) begin
         miscompares++;
         $display("FAIL hang_cycles: got %0d want %0d", n, TIMEOUT);
      end
      vectors++;
      if (bus.busy !== 1'b1 || bus.mul_start !== 1'b0 || bus.done !== '0) begin
         miscompares++;
         $display("FAIL hang_state: got busy=%b start=%b done=%b want 1/0/00", bus.busy, bus.mul_start, bus.done);
      end
      req = 2'b11;
      repeat (10) begin
         @(negedge clk);
         seen = seen | bus.gnt | bus.done;
      end
      vectors++;
      if (seen !== '0 || bus.timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL halt_locked: got gnt/done=%b err=%b want 00/1", seen, bus.timeout_err);
      end
      req = '0;
      hang = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_reset: got err=%b busy=%b want 0/0", bus.timeout_err, bus.busy);
      end
      rst_n = 1'b1;
   endtask
   task automatic test_reset_wait();
      exp_t e;
      logic [NREQ-1:0] seen = '0;
      a_flat = {4'd0, 4'd3};
      b_flat = {4'd0, 4'd3};
      req = 2'b01;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.gnt !== '0) break;
      end
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.gnt, bus.done, bus.result, bus.busy, bus.timeout_err, bus.mul_start, bus.mul_multiplier, bus.mul_multiplicand} !== '0) begin
         miscompares++;
         $display("FAIL wait_reset: got gnt=%b done=%b result=%0d busy=%b start=%b ops=%h/%h want all 0", bus.gnt, bus.done, bus.result, bus.busy, bus.mul_start, bus.mul_multiplier, bus.mul_multiplicand);
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         seen = seen | bus.done;
      end
      vectors++;
      if (seen !== '0) begin
         miscompares++;
         $display("FAIL wait_abandon: got done=%b want 00", seen);
      end
      a_flat = {4'd0, 4'd6};
      b_flat = {4'd0, 4'd7};
      req = 2'b01;
      exp_q.push_back({2'b01, prod(0)});
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         req = req & ~bus.gnt;
         if (bus.done !== '0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({bus.done, bus.result} !== e) begin
               miscompares++;
               $display("FAIL after_reset_done: got %b/%0d want %b/%0d", bus.done, bus.result, e.oh, e.p);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL after_reset_drain: %0d results missing want 0", exp_q.size());
         exp_q.delete();
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_wide();
      test_pair();
      test_fairness();
      test_timeout();
      test_reset_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
